uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 115 +++++++++++
 tb/tb_uart_rx_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, and a first-word-fall-through
// byte FIFO with a valid/ready pop side and one-cycle frame-error / overrun pulses.
module uart_rx_fifo #(
    parameter int WAIT  = 234,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic [7:0]             data,
    output logic                   valid,
    input  logic                   ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_err,
    output logic                   overrun
);
    localparam int CNT_W = $clog2(WAIT);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(WAIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WAIT - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic             armed;
    logic [7:0]       shreg;
    logic             bit_tick, stop_tick;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic             pop, push, full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A low line straight out of reset is not a start edge until it has been seen high.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx) state_nxt = armed ? START : BREAK;
            START:   if (baud_cnt == HALF_LAST) state_nxt = rx ? IDLE : DATA;
            DATA:    if (baud_cnt == BIT_LAST && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:    if (baud_cnt == BIT_LAST) state_nxt = rx ? IDLE : BREAK;
            BREAK:   if (rx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bit_tick  = 1'b0;
        stop_tick = 1'b0;
        case (state)
            DATA:    bit_tick  = (baud_cnt == BIT_LAST);
            STOP:    stop_tick = (baud_cnt == BIT_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            armed    <= 1'b0;
        end else begin
            if (rx) armed <= 1'b1;
            if (state != state_nxt || bit_tick || state == IDLE || state == BREAK)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if (state != DATA)  bit_cnt <= '0;
            else if (bit_tick)  bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bit_tick) shreg <= {rx, shreg[7:1]};
    end

    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    assign pop   = valid && ready;
    assign full  = (count == FULL_CNT);
    assign push  = stop_tick && rx && (!full || pop);
    assign valid = (count != '0);
    assign data  = valid ? mem[rptr] : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_tick && !rx;
            overrun   <= stop_tick && rx && full && !pop;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= shreg;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are modelled at the stop-sample instant,
// a negedge monitor checks occupancy, popped bytes and error pulses.
module tb_uart_rx_fifo;
    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, rx, ready;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       frame_err, overrun;

    always #5 clk = ~clk;

    uart_rx_fifo #(.WAIT(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx(rx), .data(data), .valid(valid),
        .ready(ready), .count(count), .frame_err(frame_err), .overrun(overrun)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic       exp_ferr = 1'b0;
    logic       exp_ovr  = 1'b0;
    bit         rand_on  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: at the stop-sample instant a good byte joins the FIFO unless it is full.
    task automatic model_stop(input logic [7:0] b, input logic stop);
        if (!stop)                      exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH)  exp_q.push_back(b);
        else                            exp_ovr = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1 rx = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit pulse_ready, input int hold);
        logic [9:0] frm;
        frm = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < W; j++) begin
                @(posedge clk); #1;
                rx = frm[k];
                if (k == 9 && pulse_ready && j == W / 2) ready = 1'b1;
                if (k == 9 && j == W / 2 + 1) begin
                    if (pulse_ready) ready = 1'b0;
                    model_stop(b, stop);
                end
            end
        end
        if (!stop) begin
            repeat (hold) @(posedge clk);
            idle(2);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("count", int'(count), exp_q.size());
            chk("valid", int'(valid), int'(exp_q.size() != 0));
            if (frame_err || exp_ferr) chk("frame_err", int'(frame_err), int'(exp_ferr));
            if (overrun || exp_ovr)    chk("overrun", int'(overrun), int'(exp_ovr));
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            if (valid && ready && exp_q.size() != 0)
                chk("pop_data", int'(data), int'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         hold;
        reset = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_ovr", int'(overrun), 0);
        @(posedge clk); #1 reset = 1'b0;
        idle(5);

        // single byte, popped as soon as it appears
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        idle(5);

        // short start glitch, then a real frame
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        idle(20);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        idle(5);

        // bad stop bit with a long break, then a good frame
        send_frame(8'h55, 1'b0, 1'b0, 64);
        idle(10);
        send_frame(8'h81, 1'b1, 1'b0, 0);
        idle(5);

        // fill, overrun on the fifth byte, then drain
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
        idle(3);
        chk("full_count", int'(count), 4);
        ready = 1'b1;
        idle(10);

        // full FIFO, pop exactly at the fifth stop sample
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
        send_frame(8'h05, 1'b1, 1'b1, 0);
        idle(3);
        chk("full_pop_count", int'(count), 4);
        ready = 1'b1;
        idle(10);

        // reset mid-frame with two bytes buffered, line low at release
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        @(posedge clk); #1 rx = 1'b0;
        repeat (W + 3 * W + W / 2) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_count", int'(count), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        idle(20);
        ready = 1'b1;
        send_frame(8'hF0, 1'b1, 1'b0, 0);
        idle(5);

        // randomized traffic with bursty consumer
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    rb   = 8'($urandom);
                    rs   = ($urandom_range(0, 7) != 0);
                    hold = int'($urandom_range(0, 20));
                    send_frame(rb, rs, 1'b0, hold);
                    idle(int'($urandom_range(0, 3)));
                end
                rand_on = 1'b0;
            end
            begin
                int left;
                left = 0;
                while (rand_on) begin
                    if (left == 0) begin
                        ready = 1'($urandom_range(0, 1));
                        left  = int'($urandom_range(1, 800));
                    end
                    left--;
                    @(posedge clk); #1;
                end
            end
        join

        ready = 1'b1;
        idle(30);
        chk("drain_count", int'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
